tdpr_fifo_ctrl: RTL and testbench

- First-word-fall-through FIFO controller that sits directly upstream of the true dual-port RAM and drives its ports.
- Port A is write-only (producer side). Port B is read-only (consumer side).
- Adds valid/ready handshakes on both sides and a 2-entry output skid buffer, which hides the RAM's 1-cycle registered read and sustains 1 word/cycle.
- The RAM itself stays a separate instance; this block only generates its controls and captures `dout_b`.

---
 rtl/tdpr_pkg.sv | 18 +
 rtl/tdpr_out_skid.sv | 60 ++++++
 rtl/tdpr_fifo_ctrl.sv | 95 +++++++++
 tb/tb_tdpr_fifo_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdpr_pkg.sv
// Shared constants and width helpers for the true dual-port RAM FIFO controller,
// the RAM itself and its testbench.
package tdpr_pkg;

    localparam int unsigned DEF_ADDR_SIZE = 8;
    localparam int unsigned DEF_DATA_SIZE = 8;
    // Level counts RAM words plus one in-flight read plus the 2-entry skid.
    localparam int unsigned LEVEL_EXTRA_BITS = 2;

    function automatic int unsigned ptr_width(input int unsigned addr_size);
        return addr_size + 1;
    endfunction

    function automatic int unsigned level_width(input int unsigned addr_size);
        return addr_size + LEVEL_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/tdpr_out_skid.sv
// Two-entry output FIFO that captures the RAM's registered read data; the head
// entry drives the consumer directly.
module tdpr_out_skid
    import tdpr_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DEF_DATA_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_push,
    input  logic [DATA_SIZE-1:0] i_din,
    input  logic                 i_pop,
    output logic [DATA_SIZE-1:0] o_dout,
    output logic [1:0]           o_cnt,
    output logic                 o_valid
);

    logic [DATA_SIZE-1:0] r_head;
    logic [DATA_SIZE-1:0] r_tail;
    logic [1:0]           r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_head <= i_din;
                    end else begin
                        r_tail <= i_din;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind the survivor.
                    if (r_cnt == 2'd1) begin
                        r_head <= i_din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_dout  = r_head;
    assign o_cnt   = r_cnt;
    assign o_valid = (r_cnt != 2'd0);

endmodule

// File: rtl/tdpr_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external true dual-port RAM:
// port A writes from the producer, port B reads into a 2-entry output skid buffer.
module tdpr_fifo_ctrl
    import tdpr_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int unsigned DATA_SIZE = DEF_DATA_SIZE
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_s_valid,
    output logic                              o_s_ready,
    input  logic [DATA_SIZE-1:0]              i_s_data,
    output logic                              o_m_valid,
    input  logic                              i_m_ready,
    output logic [DATA_SIZE-1:0]              o_m_data,
    output logic                              o_ram_en_a,
    output logic                              o_ram_we_a,
    output logic [ADDR_SIZE-1:0]              o_ram_addr_a,
    output logic [DATA_SIZE-1:0]              o_ram_din_a,
    output logic                              o_ram_en_b,
    output logic                              o_ram_we_b,
    output logic [ADDR_SIZE-1:0]              o_ram_addr_b,
    input  logic [DATA_SIZE-1:0]              i_ram_dout_b,
    output logic                              o_full,
    output logic [level_width(ADDR_SIZE)-1:0] o_level
);

    localparam int unsigned PW       = ptr_width(ADDR_SIZE);
    localparam int unsigned LW       = level_width(ADDR_SIZE);
    localparam int unsigned RAM_SIZE = 1 << ADDR_SIZE;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_inflight;
    logic [PW-1:0] w_ram_cnt;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_issue;
    logic          w_m_valid;
    logic [1:0]    w_skid_cnt;
    logic [2:0]    w_skid_occ;

    assign w_ram_cnt = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_ram_cnt == PW'(RAM_SIZE));
    assign o_s_ready = !i_rst && !w_full;
    assign w_push    = i_s_valid && o_s_ready;
    assign w_pop     = w_m_valid && i_m_ready;

    // Skid slots still claimed after this cycle's pop; an issue needs one free.
    assign w_skid_occ = {1'b0, w_skid_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue    = !i_rst && (w_ram_cnt != '0) && (w_skid_occ < 3'd2);

    always_comb begin
        o_ram_en_a   = w_push;
        o_ram_we_a   = w_push;
        o_ram_addr_a = r_wr_ptr[ADDR_SIZE-1:0];
        o_ram_din_a  = i_s_data;
        o_ram_en_b   = w_issue;
        o_ram_we_b   = 1'b0;
        o_ram_addr_b = r_rd_ptr[ADDR_SIZE-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + PW'(w_push);
            r_rd_ptr   <= r_rd_ptr + PW'(w_issue);
            r_inflight <= w_issue;
        end
    end

    // Capture is gated by r_inflight so the RAM's undriven read bus is never sampled.
    tdpr_out_skid #(
        .DATA_SIZE (DATA_SIZE)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_inflight),
        .i_din   (i_ram_dout_b),
        .i_pop   (w_pop),
        .o_dout  (o_m_data),
        .o_cnt   (w_skid_cnt),
        .o_valid (w_m_valid)
    );

    assign o_m_valid = w_m_valid;
    assign o_full    = w_full;
    assign o_level   = LW'(w_ram_cnt) + LW'(r_inflight) + LW'(w_skid_cnt);

endmodule

// File: tb/tb_tdpr_fifo_ctrl.sv
// Randomized and directed bench for tdpr_fifo_ctrl with a behavioural RAM attached,
// checked against a queue-based model of where each accepted word currently sits.
module tb_tdpr_fifo_ctrl;
    import tdpr_pkg::*;

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 8;
    localparam int unsigned RS = 1 << AW;
    localparam int unsigned LW = level_width(AW);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          ram_en_a, ram_we_a, ram_en_b, ram_we_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_din_a;
    logic [DW-1:0] ram_dout_b = '0;
    logic          full;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    tdpr_fifo_ctrl #(
        .ADDR_SIZE (AW),
        .DATA_SIZE (DW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_s_valid    (s_valid),
        .o_s_ready    (s_ready),
        .i_s_data     (s_data),
        .o_m_valid    (m_valid),
        .i_m_ready    (m_ready),
        .o_m_data     (m_data),
        .o_ram_en_a   (ram_en_a),
        .o_ram_we_a   (ram_we_a),
        .o_ram_addr_a (ram_addr_a),
        .o_ram_din_a  (ram_din_a),
        .o_ram_en_b   (ram_en_b),
        .o_ram_we_b   (ram_we_b),
        .o_ram_addr_b (ram_addr_b),
        .i_ram_dout_b (ram_dout_b),
        .o_full       (full),
        .o_level      (level)
    );

    // Behavioural true dual-port RAM with registered read on port B.
    logic [DW-1:0] mem [RS];
    always @(posedge clk) begin
        if (ram_en_a && ram_we_a) mem[ram_addr_a] <= ram_din_a;
        if (ram_en_b) ram_dout_b <= mem[ram_addr_b];
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: words unread in RAM, the one read in flight, the output buffer.
    logic [DW-1:0] ram_q[$];
    logic [DW-1:0] skid_q[$];
    logic [DW-1:0] sb[$];
    bit            infl = 1'b0;
    logic [DW-1:0] infl_d = '0;
    int unsigned   wr_n = 0;
    int unsigned   rd_n = 0;
    bit            mdata_zero = 1'b1;

    bit          smp_mv, smp_sr, smp_full, smp_push;
    int unsigned smp_level;
    logic [DW-1:0] smp_md;
    int unsigned n_out = 0;

    function automatic int unsigned mlevel();
        return ram_q.size() + (infl ? 1 : 0) + skid_q.size();
    endfunction

    task automatic cycle(input bit r, input bit sv, input logic [DW-1:0] sd, input bit mr);
        bit exp_mv, exp_full, exp_sr, push, pop, issue;
        int occ;
        rst = r; s_valid = sv; s_data = sd; m_ready = mr;
        #1;
        exp_mv   = (skid_q.size() != 0);
        exp_full = (ram_q.size() == RS);
        exp_sr   = !r && !exp_full;
        push     = sv && exp_sr;
        pop      = exp_mv && mr;
        occ      = skid_q.size() + (infl ? 1 : 0) - (pop ? 1 : 0);
        issue    = !r && (ram_q.size() != 0) && (occ < 2);

        smp_mv = m_valid; smp_sr = s_ready; smp_full = full;
        smp_level = 32'(level); smp_md = m_data; smp_push = push;

        chk("m_valid", 32'(m_valid), 32'(exp_mv));
        chk("s_ready", 32'(s_ready), 32'(exp_sr));
        chk("full", 32'(full), 32'(exp_full));
        chk("level", 32'(level), mlevel());
        chk("ram_en_a", 32'(ram_en_a), 32'(push));
        chk("ram_we_a", 32'(ram_we_a), 32'(push));
        chk("ram_en_b", 32'(ram_en_b), 32'(issue));
        chk("ram_we_b", 32'(ram_we_b), 32'd0);
        if (push) begin
            chk("addr_a", 32'(ram_addr_a), wr_n % RS);
            chk("din_a", 32'(ram_din_a), 32'(sd));
        end
        if (issue) chk("addr_b", 32'(ram_addr_b), rd_n % RS);
        if (exp_mv) chk("m_data", 32'(m_data), 32'(skid_q[0]));
        else if (mdata_zero) chk("m_data_rst", 32'(m_data), 32'd0);

        // Independent ordering scoreboard driven by the DUT's own handshake.
        if (m_valid && mr) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("order", 32'(m_data), 32'(sb.pop_front()));
            n_out++;
        end

        if (r) begin
            ram_q.delete(); skid_q.delete(); sb.delete();
            infl = 1'b0; wr_n = 0; rd_n = 0; mdata_zero = 1'b1;
        end else begin
            if (pop) void'(skid_q.pop_front());
            if (infl) begin
                skid_q.push_back(infl_d);
                mdata_zero = 1'b0;
            end
            infl = issue;
            if (issue) begin
                infl_d = ram_q.pop_front();
                rd_n++;
            end
            if (push) begin
                ram_q.push_back(sd);
                sb.push_back(sd);
                wr_n++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int unsigned lat, gaps, start_out, wdog;
        bit seen;
        logic [DW-1:0] d;

        @(negedge clk);
        @(negedge clk);
        cycle(1'b1, 1'b1, 8'h55, 1'b1);   // outputs under reset, then reset applied
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("post_rst_s_ready", 32'(smp_sr), 32'd1);
        chk("post_rst_level", smp_level, 32'd0);

        // Single word latency
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b1, 8'hA5, 1'b1);
        lat = 0;
        do begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            lat++;
        end while (!smp_mv && lat < 10);
        chk("latency", lat, 32'd3);
        chk("single_data", 32'(smp_md), 32'hA5);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("single_level_back", smp_level, 32'd0);

        // Fill with consumer stalled
        for (int v = 1; v <= 7; v++) begin
            cycle(1'b0, 1'b1, DW'(v), 1'b0);
            if (v == 7) chk("fill_sready_at_7", 32'(smp_sr), 32'd0);
        end
        chk("fill_full", 32'(smp_full), 32'd1);
        chk("fill_level", smp_level, 32'd6);

        // Pop while full with a push offered: slot frees one cycle later
        cycle(1'b0, 1'b1, 8'h08, 1'b1);
        chk("full_pop_sready_now", 32'(smp_sr), 32'd0);
        cycle(1'b0, 1'b1, 8'h08, 1'b0);
        chk("full_pop_sready_next", 32'(smp_sr), 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk("full_pop_level", smp_level, 32'd6);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("drained", smp_level, 32'd0);

        // Continuous stream with several pointer wraps
        start_out = n_out; gaps = 0; seen = 1'b0;
        for (int v = 0; v < 32; v++) begin
            cycle(1'b0, 1'b1, DW'(v), 1'b1);
            if (smp_mv) seen = 1'b1;
            else if (seen && (n_out - start_out) < 32) gaps++;
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            if (!smp_mv && seen && (n_out - start_out) < 32) gaps++;
        end
        chk("stream_count", n_out - start_out, 32'd32);
        chk("stream_gaps", gaps, 32'd0);

        // Random consumer backpressure against a continuous source
        d = 8'h40;
        for (int i = 0; i < 400; i++) begin
            cycle(1'b0, 1'b1, d, 1'($urandom_range(1)));
            if (smp_push) d = d + 8'd1;
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Random both sides
        for (int i = 0; i < 400; i++) begin
            cycle(1'b0, 1'($urandom_range(1)), 8'($urandom), 1'($urandom_range(1)));
        end

        // Reset mid-stream at level 5
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        wdog = 0;
        while (mlevel() != 5 && wdog < 20) begin
            cycle(1'b0, 1'b1, 8'(8'h90 + wdog), 1'b0);
            wdog++;
        end
        chk("reach_level5", mlevel(), 32'd5);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 8'h3C, 1'b1);
        chk("rst_mid_m_valid", 32'(smp_mv), 32'd0);
        chk("rst_mid_level", smp_level, 32'd0);
        chk("rst_mid_full", 32'(smp_full), 32'd0);
        chk("rst_mid_s_ready", 32'(smp_sr), 32'd1);
        wdog = 0;
        do begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            wdog++;
        end while (!smp_mv && wdog < 10);
        chk("rst_mid_first_valid", 32'(smp_mv), 32'd1);
        chk("rst_mid_first_data", 32'(smp_md), 32'h3C);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
